// File: rtl/rvfi_dmem_multi_check.sv
// rvfi_dmem_multi_check
//   Data-memory consistency checker for an RVFI retirement trace. A set of
//   NADDR aligned words is shadowed byte by byte; every byte read through
//   RVFI from a watched word is compared against the last byte written there.
//   Optionally checks that rvfi_order advances by exactly one per retirement.
//   The first violation is latched into sticky, registered status outputs.
//
// Ports
//   clk            clock
//   resetn         synchronous, active-low reset
//   watch_addr     NADDR watched word addresses (low log2(NB) bits ignored)
//   rvfi_valid     per-channel retire valid
//   rvfi_order     per-channel instruction order
//   rvfi_mem_addr  per-channel access address
//   rvfi_mem_rmask per-channel byte read mask
//   rvfi_mem_wmask per-channel byte write mask
//   rvfi_mem_rdata per-channel read data
//   rvfi_mem_wdata per-channel write data
//   err            sticky error flag
//   err_kind       0 none, 1 data mismatch, 2 order violation
//   err_chan       channel of the first error
//   err_slot       watched slot of the first data error (0 for order errors)
//   err_byte       byte lane of the first data error (0 for order errors)
//   check_cnt      saturating count of byte comparisons performed
module rvfi_dmem_multi_check #(
    parameter int XLEN        = 32,
    parameter int NRET        = 1,
    parameter int NADDR       = 2,
    parameter int ORDER_W     = 64,
    parameter int CHECK_ORDER = 1,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NADDR*XLEN-1:0]   watch_addr,
    input  logic [NRET-1:0]         rvfi_valid,
    input  logic [NRET*ORDER_W-1:0] rvfi_order,
    input  logic [NRET*XLEN-1:0]    rvfi_mem_addr,
    input  logic [NRET*XLEN/8-1:0]  rvfi_mem_rmask,
    input  logic [NRET*XLEN/8-1:0]  rvfi_mem_wmask,
    input  logic [NRET*XLEN-1:0]    rvfi_mem_rdata,
    input  logic [NRET*XLEN-1:0]    rvfi_mem_wdata,
    output logic                    err,
    output logic [1:0]              err_kind,
    output logic [1:0]              err_chan,
    output logic [2:0]              err_slot,
    output logic [2:0]              err_byte,
    output logic [CNT_W-1:0]        check_cnt
);

    localparam int NB = XLEN / 8;
    localparam logic [XLEN-1:0]  LOW_MASK = XLEN'(NB - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Shadow state: registered copy and the next value built by the chain.
    logic [NADDR-1:0][NB-1:0][7:0] shadow_r,  shadow_s;
    logic [NADDR-1:0][NB-1:0]      written_r, written_s;
    logic                          order_seen_r, order_seen_s;
    logic [ORDER_W-1:0]            exp_order_r,  exp_order_s;

    logic              err_r,      err_s;
    logic [1:0]        err_kind_r, err_kind_s;
    logic [1:0]        err_chan_r, err_chan_s;
    logic [2:0]        err_slot_r, err_slot_s;
    logic [2:0]        err_byte_r, err_byte_s;
    logic [CNT_W-1:0]  cnt_r,      cnt_s;

    // Per-iteration temporaries of the combinational chain.
    logic [ORDER_W-1:0] ord_s;
    logic               hit_s;
    logic               cap_s;
    logic               inc_s;
    logic               wr_s;

    // Walk channels in ascending order so later channels see earlier writes;
    // err_s doubles as the "first error already taken" flag for priority.
    always_comb begin
        shadow_s     = shadow_r;
        written_s    = written_r;
        order_seen_s = order_seen_r;
        exp_order_s  = exp_order_r;
        err_s        = err_r;
        err_kind_s   = err_kind_r;
        err_chan_s   = err_chan_r;
        err_slot_s   = err_slot_r;
        err_byte_s   = err_byte_r;
        cnt_s        = cnt_r;
        ord_s        = '0;
        hit_s        = 1'b0;
        cap_s        = 1'b0;
        inc_s        = 1'b0;
        wr_s         = 1'b0;
        for (int c = 0; c < NRET; c++) begin
            // Order check precedes this channel's data checks.
            ord_s      = rvfi_order[c*ORDER_W +: ORDER_W];
            cap_s      = (CHECK_ORDER != 0) && rvfi_valid[c] && order_seen_s
                         && (ord_s != exp_order_s) && !err_s;
            err_kind_s = cap_s ? 2'd2    : err_kind_s;
            err_chan_s = cap_s ? 2'(c)   : err_chan_s;
            err_slot_s = cap_s ? 3'd0    : err_slot_s;
            err_byte_s = cap_s ? 3'd0    : err_byte_s;
            err_s      = err_s | cap_s;
            order_seen_s = order_seen_s | rvfi_valid[c];
            exp_order_s  = rvfi_valid[c] ? (ord_s + ORDER_W'(1)) : exp_order_s;

            for (int s = 0; s < NADDR; s++) begin
                hit_s = rvfi_valid[c] &&
                        ((rvfi_mem_addr[c*XLEN +: XLEN] & ~LOW_MASK) ==
                         (watch_addr[s*XLEN +: XLEN] & ~LOW_MASK));
                // Reads compare against the value before this channel's write.
                for (int i = 0; i < NB; i++) begin
                    inc_s      = hit_s && rvfi_mem_rmask[c*NB + i] && written_s[s][i];
                    cnt_s      = (inc_s && (cnt_s != CNT_MAX)) ? (cnt_s + CNT_W'(1)) : cnt_s;
                    cap_s      = inc_s && !err_s &&
                                 (shadow_s[s][i] != rvfi_mem_rdata[c*XLEN + i*8 +: 8]);
                    err_kind_s = cap_s ? 2'd1  : err_kind_s;
                    err_chan_s = cap_s ? 2'(c) : err_chan_s;
                    err_slot_s = cap_s ? 3'(s) : err_slot_s;
                    err_byte_s = cap_s ? 3'(i) : err_byte_s;
                    err_s      = err_s | cap_s;
                end
                for (int i = 0; i < NB; i++) begin
                    wr_s            = hit_s && rvfi_mem_wmask[c*NB + i];
                    shadow_s[s][i]  = wr_s ? rvfi_mem_wdata[c*XLEN + i*8 +: 8] : shadow_s[s][i];
                    written_s[s][i] = written_s[s][i] | wr_s;
                end
            end
        end
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            written_r    <= '0;
            order_seen_r <= 1'b0;
            err_r        <= 1'b0;
            err_kind_r   <= 2'd0;
            err_chan_r   <= 2'd0;
            err_slot_r   <= 3'd0;
            err_byte_r   <= 3'd0;
            cnt_r        <= '0;
        end else begin
            written_r    <= written_s;
            order_seen_r <= order_seen_s;
            err_r        <= err_s;
            err_kind_r   <= err_kind_s;
            err_chan_r   <= err_chan_s;
            err_slot_r   <= err_slot_s;
            err_byte_r   <= err_byte_s;
            cnt_r        <= cnt_s;
        end
    end

    // Shadow bytes and expected order are qualified by written/order_seen,
    // so they need no reset.
    always_ff @(posedge clk) begin
        shadow_r    <= shadow_s;
        exp_order_r <= exp_order_s;
    end

    assign err       = err_r;
    assign err_kind  = err_kind_r;
    assign err_chan  = err_chan_r;
    assign err_slot  = err_slot_r;
    assign err_byte  = err_byte_r;
    assign check_cnt = cnt_r;

endmodule

// File: tb/tb_rvfi_dmem_multi_check.sv
// Testbench for rvfi_dmem_multi_check. Two instances share the same trace:
// dut_a checks order (CNT_W=16), dut_b does not (CNT_W=4, so the counter
// saturates quickly). Expected status is queued when a cycle is driven and
// popped after the clock edge that registers it.
module tb_rvfi_dmem_multi_check;

    typedef struct {
        logic        v;
        logic [63:0] o;
        logic [31:0] a;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] rd;
        logic [31:0] wd;
    } ch_t;

    typedef struct {
        logic        err;
        logic [1:0]  kind;
        logic [1:0]  chan;
        logic [2:0]  slot;
        logic [2:0]  byt;
        int          cnt;
        logic        b_err;
        logic [1:0]  b_kind;
    } exp_t;

    typedef struct {
        logic rst;
        ch_t  c0;
        ch_t  c1;
        exp_t e;
    } vec_t;

    logic         clk;
    logic         resetn;
    logic [63:0]  watch_addr;
    logic [1:0]   rvfi_valid;
    logic [127:0] rvfi_order;
    logic [63:0]  rvfi_mem_addr;
    logic [7:0]   rvfi_mem_rmask;
    logic [7:0]   rvfi_mem_wmask;
    logic [63:0]  rvfi_mem_rdata;
    logic [63:0]  rvfi_mem_wdata;

    logic         a_err, b_err;
    logic [1:0]   a_kind, b_kind, a_chan, b_chan;
    logic [2:0]   a_slot, b_slot, a_byte, b_byte;
    logic [15:0]  a_cnt;
    logic [3:0]   b_cnt;

    rvfi_dmem_multi_check #(.XLEN(32), .NRET(2), .NADDR(2), .ORDER_W(64),
                            .CHECK_ORDER(1), .CNT_W(16)) dut_a (
        .clk(clk), .resetn(resetn), .watch_addr(watch_addr),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata),
        .err(a_err), .err_kind(a_kind), .err_chan(a_chan),
        .err_slot(a_slot), .err_byte(a_byte), .check_cnt(a_cnt));

    rvfi_dmem_multi_check #(.XLEN(32), .NRET(2), .NADDR(2), .ORDER_W(64),
                            .CHECK_ORDER(0), .CNT_W(4)) dut_b (
        .clk(clk), .resetn(resetn), .watch_addr(watch_addr),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata),
        .err(b_err), .err_kind(b_kind), .err_chan(b_chan),
        .err_slot(b_slot), .err_byte(b_byte), .check_cnt(b_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb_q[$];
    vec_t tbl[$];

    function automatic ch_t acc(input logic v, input logic [63:0] o, input logic [31:0] a,
                                input logic [3:0] rm, input logic [3:0] wm,
                                input logic [31:0] rd, input logic [31:0] wd);
        ch_t r;
        r.v = v; r.o = o; r.a = a; r.rm = rm; r.wm = wm; r.rd = rd; r.wd = wd;
        return r;
    endfunction

    function automatic ch_t wr(input logic [63:0] o, input logic [31:0] a,
                               input logic [3:0] wm, input logic [31:0] wd);
        return acc(1'b1, o, a, 4'h0, wm, 32'h0, wd);
    endfunction

    function automatic ch_t rd(input logic [63:0] o, input logic [31:0] a,
                               input logic [3:0] rm, input logic [31:0] rdv);
        return acc(1'b1, o, a, rm, 4'h0, rdv, 32'h0);
    endfunction

    function automatic ch_t none();
        return acc(1'b0, 64'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    endfunction

    function automatic exp_t ex(input logic err, input logic [1:0] kind, input logic [1:0] chan,
                                input logic [2:0] slot, input logic [2:0] byt, input int cnt,
                                input logic berr, input logic [1:0] bkind);
        exp_t r;
        r.err = err; r.kind = kind; r.chan = chan; r.slot = slot; r.byt = byt;
        r.cnt = cnt; r.b_err = berr; r.b_kind = bkind;
        return r;
    endfunction

    function automatic exp_t ok(input int cnt);
        return ex(1'b0, 2'd0, 2'd0, 3'd0, 3'd0, cnt, 1'b0, 2'd0);
    endfunction

    task automatic add(input logic rst, input ch_t c0, input ch_t c1, input exp_t e);
        vec_t v;
        v.rst = rst; v.c0 = c0; v.c1 = c1; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] want);
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, want);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        int   bcnt;
        @(negedge clk);
        resetn         = v.rst ? 1'b0 : 1'b1;
        rvfi_valid     = {v.c1.v, v.c0.v};
        rvfi_order     = {v.c1.o, v.c0.o};
        rvfi_mem_addr  = {v.c1.a, v.c0.a};
        rvfi_mem_rmask = {v.c1.rm, v.c0.rm};
        rvfi_mem_wmask = {v.c1.wm, v.c0.wm};
        rvfi_mem_rdata = {v.c1.rd, v.c0.rd};
        rvfi_mem_wdata = {v.c1.wd, v.c0.wd};
        sb_q.push_back(v.e);
        n_vec++;
        @(posedge clk);
        #1;
        e    = sb_q.pop_front();
        bcnt = (e.cnt > 15) ? 15 : e.cnt;
        chk("err",        idx, 64'(a_err),  64'(e.err));
        chk("err_kind",   idx, 64'(a_kind), 64'(e.kind));
        chk("err_chan",   idx, 64'(a_chan), 64'(e.chan));
        chk("err_slot",   idx, 64'(a_slot), 64'(e.slot));
        chk("err_byte",   idx, 64'(a_byte), 64'(e.byt));
        chk("check_cnt",  idx, 64'(a_cnt),  64'(e.cnt));
        chk("b_err",      idx, 64'(b_err),  64'(e.b_err));
        chk("b_err_kind", idx, 64'(b_kind), 64'(e.b_kind));
        chk("b_check_cnt", idx, 64'(b_cnt), 64'(bcnt));
    endtask

    initial begin
        vec_t hv;
        resetn         = 1'b0;
        watch_addr     = {32'h0000_0104, 32'h0000_0100};
        rvfi_valid     = 2'b00;
        rvfi_order     = '0;
        rvfi_mem_addr  = '0;
        rvfi_mem_rmask = '0;
        rvfi_mem_wmask = '0;
        rvfi_mem_rdata = '0;
        rvfi_mem_wdata = '0;

        // Write, correct reads, unwritten slot, mismatch, sticky, saturation.
        add(1'b1, none(), none(), ok(0));
        add(1'b0, wr(64'd10, 32'h100, 4'hF, 32'hDEADBEEF), none(), ok(0));
        add(1'b0, rd(64'd11, 32'h100, 4'hF, 32'hDEADBEEF), none(), ok(4));
        add(1'b0, rd(64'd12, 32'h101, 4'h2, 32'h0000BE00), none(), ok(5));
        add(1'b0, rd(64'd13, 32'h104, 4'hF, 32'h12345678), none(), ok(5));
        add(1'b0, rd(64'd14, 32'h100, 4'hF, 32'hDEADBEFF), none(), ex(1, 1, 0, 0, 0, 9, 1, 1));
        add(1'b0, rd(64'd15, 32'h100, 4'hF, 32'h0), none(), ex(1, 1, 0, 0, 0, 13, 1, 1));
        add(1'b0, rd(64'd16, 32'h100, 4'hF, 32'h0), none(), ex(1, 1, 0, 0, 0, 17, 1, 1));
        // Reset discards shadow contents.
        add(1'b1, none(), none(), ok(0));
        add(1'b0, wr(64'd0, 32'h100, 4'hF, 32'hAAAAAAAA), none(), ok(0));
        add(1'b1, none(), none(), ok(0));
        add(1'b0, rd(64'd1, 32'h100, 4'hF, 32'h55555555), none(), ok(0));
        // Same-cycle forwarding from channel 0 to channel 1.
        add(1'b0, wr(64'd2, 32'h104, 4'h4, 32'h00110000), rd(64'd3, 32'h107, 4'h4, 32'h00110000), ok(1));
        add(1'b0, wr(64'd4, 32'h104, 4'h4, 32'h00330000), rd(64'd5, 32'h107, 4'h4, 32'h00220000),
            ex(1, 1, 1, 1, 2, 2, 1, 1));
        // Read-and-write in one access checks the pre-write value; invalid ignored.
        add(1'b1, none(), none(), ok(0));
        add(1'b0, wr(64'd0, 32'h100, 4'hF, 32'h01020304), none(), ok(0));
        add(1'b0, acc(1'b1, 64'd1, 32'h100, 4'hF, 4'hF, 32'h01020304, 32'hFFFFFFFF), none(), ok(4));
        add(1'b0, rd(64'd2, 32'h100, 4'hF, 32'hFFFFFFFF), none(), ok(8));
        add(1'b0, none(), acc(1'b0, 64'd9, 32'h100, 4'hF, 4'hF, 32'h0, 32'h0), ok(8));
        add(1'b0, rd(64'd3, 32'h100, 4'hF, 32'hFFFFFFFF), none(), ok(12));
        // Order sequence 5, 6, 8.
        add(1'b1, none(), none(), ok(0));
        add(1'b0, rd(64'd5, 32'h200, 4'h0, 32'h0), none(), ok(0));
        add(1'b0, rd(64'd6, 32'h200, 4'h0, 32'h0), none(), ok(0));
        add(1'b0, rd(64'd8, 32'h200, 4'h0, 32'h0), none(), ex(1, 2, 0, 0, 0, 0, 0, 0));
        add(1'b0, rd(64'd9, 32'h200, 4'h0, 32'h0), none(), ex(1, 2, 0, 0, 0, 0, 0, 0));
        // Order wrap, two channels, invalid skip, channel-1 order error.
        add(1'b1, none(), none(), ok(0));
        add(1'b0, rd(64'hFFFF_FFFF_FFFF_FFFF, 32'h200, 4'h0, 32'h0), none(), ok(0));
        add(1'b0, rd(64'd0, 32'h200, 4'h0, 32'h0), none(), ok(0));
        add(1'b0, rd(64'd1, 32'h200, 4'h0, 32'h0), rd(64'd2, 32'h200, 4'h0, 32'h0), ok(0));
        add(1'b0, none(), rd(64'd3, 32'h200, 4'h0, 32'h0), ok(0));
        add(1'b0, none(), rd(64'd5, 32'h200, 4'h0, 32'h0), ex(1, 2, 1, 0, 0, 0, 0, 0));
        // Simultaneous order error (ch0) and data error (ch1).
        add(1'b1, none(), none(), ok(0));
        add(1'b0, wr(64'd0, 32'h100, 4'hF, 32'hCAFEF00D), none(), ok(0));
        add(1'b0, rd(64'd5, 32'h100, 4'hF, 32'hCAFEF00D), rd(64'd6, 32'h100, 4'h8, 32'h0),
            ex(1, 2, 0, 0, 0, 5, 1, 1));
        add(1'b0, rd(64'd7, 32'h100, 4'hF, 32'h0), none(), ex(1, 2, 0, 0, 0, 9, 1, 1));

        foreach (tbl[k]) apply(tbl[k], k);

        // Hand sequence: assemble slot 1 one lane per cycle, then read it back.
        hv.rst = 1'b1; hv.c0 = none(); hv.c1 = none(); hv.e = ok(0);
        apply(hv, 100);
        for (int i = 0; i < 4; i++) begin
            hv.rst = 1'b0;
            hv.c0  = wr(64'(i), 32'h104, 4'(1 << i), (32'h40 + 32'(i)) << (8 * i));
            hv.e   = ok(0);
            apply(hv, 101 + i);
        end
        hv.c0 = rd(64'd4, 32'h104, 4'hF, 32'h43424140);
        hv.e  = ok(4);
        apply(hv, 105);
        hv.c0 = rd(64'd5, 32'h104, 4'hF, 32'h43424141);
        hv.e  = ex(1, 1, 0, 1, 0, 8, 1, 1);
        apply(hv, 106);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
